id_hazard_scoreboard: RTL and testbench

//  Parametrised register scoreboard for the ID stage; generalises ID branch-hazard stall logic
//  to NUM_SRC source operands and variable-latency writers (ALU, load, multi-cycle mul/div).

---
 rtl/id_hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_id_hazard_scoreboard.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - ID-stage register scoreboard with RAW/WAW stall and EX-flush recovery
// Optional: define SCOREBOARD_PERF_EN to add RAW/WAW stall-cycle counters.
module id_hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LAT_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic                      issue_valid,
    input  logic                      issue_regwrite,
    input  logic [ADDR_W-1:0]         issue_rd,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic                      flush,
    output logic [NUM_SRC-1:0]        src_hazard,
    output logic                      waw_hazard,
    output logic                      stall,
    output logic [NUM_REGS-1:0]       busy
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]               perf_raw_cycles,
    output logic [31:0]               perf_waw_cycles
`endif
);

    logic [LAT_W-1:0]  r_cnt [NUM_REGS];
    logic              r_last_valid;
    logic [ADDR_W-1:0] r_last_rd;
    logic [LAT_W-1:0]  r_last_prev_cnt;

    logic              w_rd_nz;
    logic              w_issue_fire;
    logic              w_wr_fire;
    logic [LAT_W-1:0]  w_restore;

    genvar g;
    for (g = 0; g < NUM_SRC; g++) begin : g_src
        logic [ADDR_W-1:0] w_addr;
        assign w_addr        = src_addr[g*ADDR_W +: ADDR_W];
        assign src_hazard[g] = src_en[g] && (w_addr != '0) && (r_cnt[w_addr] != '0);
    end

    assign w_rd_nz      = (issue_rd != '0);
    assign waw_hazard   = issue_valid && issue_regwrite && w_rd_nz && (r_cnt[issue_rd] > issue_lat);
    assign stall        = (|src_hazard) || waw_hazard;
    assign w_issue_fire = issue_valid && !stall && !flush;
    assign w_wr_fire    = w_issue_fire && issue_regwrite && w_rd_nz;

    // The squashed writer overwrote an older writer's count two edges ago; rewind that count.
    assign w_restore = (r_last_prev_cnt > LAT_W'(2)) ? (r_last_prev_cnt - LAT_W'(2)) : '0;

    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (r_cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_last_valid    <= 1'b0;
            r_last_rd       <= '0;
            r_last_prev_cnt <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r == 0) begin
                    r_cnt[r] <= '0;
                end else if (flush && r_last_valid && (r_last_rd == ADDR_W'(r))) begin
                    r_cnt[r] <= w_restore;
                end else if (w_wr_fire && (issue_rd == ADDR_W'(r))) begin
                    r_cnt[r] <= issue_lat;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - LAT_W'(1);
                end
            end
            r_last_valid <= w_wr_fire;
            if (w_wr_fire) begin
                r_last_rd       <= issue_rd;
                r_last_prev_cnt <= r_cnt[issue_rd];
            end
        end
    end

`ifdef SCOREBOARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_raw_cycles <= '0;
            perf_waw_cycles <= '0;
        end else begin
            if (issue_valid && !flush && (|src_hazard)) begin
                perf_raw_cycles <= perf_raw_cycles + 32'd1;
            end
            if (waw_hazard && !flush) begin
                perf_waw_cycles <= perf_waw_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - directed self-checking bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  src_en;
    logic [9:0]  src_addr;
    logic        issue_valid;
    logic        issue_regwrite;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_lat;
    logic        flush;
    logic [1:0]  src_hazard;
    logic        waw_hazard;
    logic        stall;
    logic [31:0] busy;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] perf_raw_cycles;
    logic [31:0] perf_waw_cycles;
`endif

    int passed = 0;
    int total  = 0;

    id_hazard_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .src_en         (src_en),
        .src_addr       (src_addr),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_rd       (issue_rd),
        .issue_lat      (issue_lat),
        .flush          (flush),
        .src_hazard     (src_hazard),
        .waw_hazard     (waw_hazard),
        .stall          (stall),
        .busy           (busy)
`ifdef SCOREBOARD_PERF_EN
        ,
        .perf_raw_cycles(perf_raw_cycles),
        .perf_waw_cycles(perf_waw_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src_en         = 2'b00;
        src_addr       = 10'd0;
        issue_valid    = 1'b0;
        issue_regwrite = 1'b0;
        issue_rd       = 5'd0;
        issue_lat      = 3'd0;
        flush          = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] lat);
        idle();
        issue_valid    = 1'b1;
        issue_regwrite = 1'b1;
        issue_rd       = rd;
        issue_lat      = lat;
    endtask

    task automatic test_reset();
        idle();
        src_en   = 2'b01;
        src_addr = 10'd5;
        #1;
        total++; if (busy !== 32'd0) $display("FAIL reset_busy got %h exp 0", busy); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else passed++;
        total++; if (src_hazard !== 2'b00 || waw_hazard !== 1'b0) $display("FAIL reset_haz got %b/%b exp 00/0", src_hazard, waw_hazard); else passed++;
        #2 rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        issue(5'd5, 3'd3);
        tick();
        idle();
        src_en   = 2'b01;
        src_addr = 10'd5;
        #1;
        total++; if (busy[5] !== 1'b1 || stall !== 1'b1) $display("FAIL pre_reset got busy5=%b stall=%b exp 1/1", busy[5], stall); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 32'd0) $display("FAIL async_reset_busy got %h exp 0", busy); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL async_reset_stall got %b exp 0", stall); else passed++;
        #1 rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_load_raw();
        issue(5'd5, 3'd2);
        tick();
        idle();
        issue_valid = 1'b1;
        src_en      = 2'b01;
        src_addr    = 10'd5;
        #1;
        total++; if (stall !== 1'b1 || src_hazard !== 2'b01) $display("FAIL raw_c1 got stall=%b haz=%b exp 1/01", stall, src_hazard); else passed++;
        tick();
        total++; if (stall !== 1'b1) $display("FAIL raw_c2 got %b exp 1", stall); else passed++;
        tick();
        total++; if (stall !== 1'b0 || src_hazard !== 2'b00) $display("FAIL raw_c3 got stall=%b haz=%b exp 0/00", stall, src_hazard); else passed++;
        tick();
        idle();
    endtask

    task automatic test_alu_back_to_back();
        issue(5'd7, 3'd0);
        tick();
        idle();
        issue_valid = 1'b1;
        src_en      = 2'b10;
        src_addr    = {5'd7, 5'd0};
        #1;
        total++; if (busy[7] !== 1'b0) $display("FAIL alu_busy got %b exp 0", busy[7]); else passed++;
        total++; if (stall !== 1'b0 || src_hazard !== 2'b00) $display("FAIL alu_stall got stall=%b haz=%b exp 0/00", stall, src_hazard); else passed++;
        tick();
        idle();
    endtask

    task automatic test_waw();
        issue(5'd3, 3'd6);
        tick();
        issue(5'd3, 3'd1);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (waw_hazard !== 1'b1 || stall !== 1'b1) $display("FAIL waw_hold%0d got waw=%b stall=%b exp 1/1", k, waw_hazard, stall); else passed++;
            tick();
        end
        total++; if (waw_hazard !== 1'b0 || stall !== 1'b0) $display("FAIL waw_clear got waw=%b stall=%b exp 0/0", waw_hazard, stall); else passed++;
        tick();
        idle();
        #1;
        total++; if (busy[3] !== 1'b1) $display("FAIL waw_newlat got %b exp 1", busy[3]); else passed++;
        tick();
        tick();
        total++; if (busy[3] !== 1'b0) $display("FAIL waw_drain got %b exp 0", busy[3]); else passed++;
    endtask

    task automatic test_flush();
        issue(5'd9, 3'd4);
        tick();
        issue(5'd9, 3'd6);
        tick();
        // Flush while ID is also stalled on r9: flush wins, ID instruction is dropped.
        issue(5'd12, 3'd2);
        src_en   = 2'b01;
        src_addr = 10'd9;
        flush    = 1'b1;
        tick();
        idle();
        issue_valid = 1'b1;
        src_en      = 2'b01;
        src_addr    = 10'd9;
        #1;
        total++; if (busy[12] !== 1'b0) $display("FAIL flush_drop got %b exp 0", busy[12]); else passed++;
        total++; if (stall !== 1'b1) $display("FAIL flush_cnt2 got %b exp 1", stall); else passed++;
        tick();
        total++; if (stall !== 1'b1) $display("FAIL flush_cnt1 got %b exp 1", stall); else passed++;
        tick();
        total++; if (stall !== 1'b0) $display("FAIL flush_cnt0 got %b exp 0", stall); else passed++;
        idle();
        tick();
        issue(5'd10, 3'd3);
        flush = 1'b1;
        tick();
        idle();
        #1;
        total++; if (busy !== 32'd0) $display("FAIL flush_noissue got %h exp 0", busy); else passed++;
    endtask

    task automatic test_x0_src_en();
        issue(5'd0, 3'd5);
        tick();
        idle();
        #1;
        total++; if (busy !== 32'd0) $display("FAIL x0_write got %h exp 0", busy); else passed++;
        issue(5'd9, 3'd3);
        tick();
        idle();
        issue_valid = 1'b1;
        src_addr    = 10'd9;
        src_en      = 2'b00;
        #1;
        total++; if (src_hazard !== 2'b00 || stall !== 1'b0) $display("FAIL src_en_off got haz=%b stall=%b exp 00/0", src_hazard, stall); else passed++;
        src_en = 2'b01;
        #1;
        total++; if (src_hazard !== 2'b01) $display("FAIL src_en_on got %b exp 01", src_hazard); else passed++;
        src_addr = {5'd9, 5'd0};
        src_en   = 2'b11;
        #1;
        total++; if (src_hazard !== 2'b10) $display("FAIL x0_read got %b exp 10", src_hazard); else passed++;
        idle();
        tick();
        tick();
        tick();
        total++; if (busy !== 32'd0) $display("FAIL x0_drain got %h exp 0", busy); else passed++;
    endtask

`ifdef SCOREBOARD_PERF_EN
    task automatic test_perf();
        idle();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        total++; if (perf_raw_cycles !== 32'd0 || perf_waw_cycles !== 32'd0) $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_raw_cycles, perf_waw_cycles); else passed++;
        tick();
        issue(5'd5, 3'd2);
        tick();
        idle();
        issue_valid = 1'b1;
        src_en      = 2'b01;
        src_addr    = 10'd5;
        tick();
        tick();
        tick();
        issue(5'd6, 3'd3);
        tick();
        issue(5'd6, 3'd1);
        tick();
        idle();
        tick();
        total++; if (perf_raw_cycles !== 32'd2) $display("FAIL perf_raw got %0d exp 2", perf_raw_cycles); else passed++;
        total++; if (perf_waw_cycles !== 32'd1) $display("FAIL perf_waw got %0d exp 1", perf_waw_cycles); else passed++;
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_async_reset();
        test_load_raw();
        test_alu_back_to_back();
        test_waw();
        test_flush();
        test_x0_src_en();
`ifdef SCOREBOARD_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
